// File: rtl/case_1_mul_share_arb.sv
// Shares one signed x unsigned multiplier among NUM_REQ requesters.
// Round-robin grant feeds a two-stage pipeline: operand register (S1), then product register (S2).
module case_1_mul_share_arb #(
   parameter int NUM_REQ    = 4,
   parameter int DIN0_WIDTH = 14,
   parameter int DIN1_WIDTH = 12,
   parameter int DOUT_WIDTH = 26
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0,
   input  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [DOUT_WIDTH-1:0]         res_dout,
   output logic [$clog2(NUM_REQ)-1:0]    res_id,
   output logic                          busy
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic                  s1_valid;
   logic [DIN0_WIDTH-1:0] s1_din0;
   logic [DIN1_WIDTH-1:0] s1_din1;
   logic [ID_W-1:0]       s1_id;
   logic                  s2_valid;

   logic [ID_W-1:0]       ptr;
   logic [ID_W-1:0]       ptr_next;
   logic [ID_W-1:0]       grant_idx;
   logic                  grant_found;
   int                    cand;

   logic                  s2_load;
   logic                  s1_can_load;
   logic                  xfer;

   logic [DOUT_WIDTH-1:0] op0;
   logic [DOUT_WIDTH-1:0] op1;
   logic [DOUT_WIDTH-1:0] product;

   assign s2_load     = !s2_valid || res_ready;
   assign s1_can_load = !s1_valid || s2_load;

   // First valid requester at or after the pointer, searching upward with wrap.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'(cand);
         end
      end
   end

   // Reset gates the grant directly so req_ready drops without waiting for an edge.
   always_comb begin
      req_ready = '0;
      if (grant_found && s1_can_load && !ap_rst) req_ready[grant_idx] = 1'b1;
   end

   assign xfer     = |req_ready;
   assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         s1_valid <= 1'b0;
         ptr      <= '0;
      end else begin
         if (s1_can_load) s1_valid <= xfer;
         if (xfer)        ptr      <= ptr_next;
      end
   end

   // NOTE: operand registers carry no reset; s1_valid alone qualifies them.
   always_ff @(posedge ap_clk) begin
      if (xfer) begin
         s1_din0 <= req_din0[grant_idx*DIN0_WIDTH +: DIN0_WIDTH];
         s1_din1 <= req_din1[grant_idx*DIN1_WIDTH +: DIN1_WIDTH];
         s1_id   <= grant_idx;
      end
   end

   // Zero-extend the unsigned operand, sign-extend the signed one; low bits give the signed product.
   assign op0     = {{(DOUT_WIDTH-DIN0_WIDTH){1'b0}}, s1_din0};
   assign op1     = {{(DOUT_WIDTH-DIN1_WIDTH){s1_din1[DIN1_WIDTH-1]}}, s1_din1};
   assign product = op0 * op1;

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         s2_valid <= 1'b0;
         res_dout <= '0;
         res_id   <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            res_dout <= product;
            res_id   <= s1_id;
         end
      end
   end

   assign res_valid = s2_valid;
   assign busy      = s1_valid || s2_valid;

endmodule
